// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the accumulator CPU control path: opcodes, control-word
// bit positions (also used by the ALU) and sequencer state codes.
package cpu_ctrl_pkg;

    localparam int CU_CW_WIDTH = 32;
    localparam int CU_OP_WIDTH = 8;

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHR    = 8'h0D;
    localparam logic [7:0] OP_SHL    = 8'h0E;
    localparam logic [7:0] OP_ASHR   = 8'h0F;
    localparam logic [7:0] OP_ASHL   = 8'h10;

    localparam int C_PC_MAR    = 0;
    localparam int C_MEM_RD    = 1;
    localparam int C_MEM_MBR   = 2;
    localparam int C_MBR_IR    = 3;
    localparam int C_IR_MAR    = 4;
    localparam int C_PC_INC    = 5;
    localparam int C_MBR_BR    = 6;
    localparam int C_ACC_MBR   = 7;
    localparam int C_MEM_WR    = 8;
    localparam int C_IR_PC     = 9;
    localparam int C_ALU_LATCH = 10;
    localparam int C_ALU_ACC   = 11;
    localparam int C_ALU_MR    = 12;
    localparam int C_CLR_OP1   = 21;
    localparam int C_ADD       = 22;
    localparam int C_SUB       = 23;
    localparam int C_AND       = 24;
    localparam int C_OR        = 25;
    localparam int C_NOT       = 26;
    localparam int C_SHL       = 27;
    localparam int C_SHR       = 28;
    localparam int C_MPY       = 29;
    localparam int C_ASHL      = 30;
    localparam int C_ASHR      = 31;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_F1     = 4'd1;
    localparam logic [3:0] S_F2     = 4'd2;
    localparam logic [3:0] S_F3     = 4'd3;
    localparam logic [3:0] S_DECODE = 4'd4;
    localparam logic [3:0] S_E1     = 4'd5;
    localparam logic [3:0] S_E2     = 4'd6;
    localparam logic [3:0] S_E3     = 4'd7;
    localparam logic [3:0] S_E4     = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    // Number of execute micro-steps; 0 marks HALT and unknown opcodes.
    function automatic logic [2:0] exec_steps(input logic [7:0] op);
        logic [2:0] steps;
        case (op)
            OP_STORE:                                         steps = 3'd3;
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MPY:   steps = 3'd4;
            OP_NOT, OP_SHR, OP_SHL, OP_ASHR, OP_ASHL,
            OP_JMP, OP_JMPGEZ:                                steps = 3'd1;
            default:                                          steps = 3'd0;
        endcase
        return steps;
    endfunction

endpackage

// File: rtl/cu_microrom.sv
// Combinational micro-ROM: maps the state being entered and the latched opcode
// to the control word that state drives.
module cu_microrom
    import cpu_ctrl_pkg::*;
#(
    parameter int CW_WIDTH = CU_CW_WIDTH,
    parameter int OP_WIDTH = CU_OP_WIDTH
) (
    input  logic [3:0]          state,
    input  logic [OP_WIDTH-1:0] op,
    input  logic                acc_neg,
    output logic [CW_WIDTH-1:0] cw
);

    // Control word lookup for the upcoming micro-step.
    always_comb begin
        cw = {CW_WIDTH{1'b0}};
        case (state)
            S_F1: cw[C_PC_MAR] = 1'b1;
            S_F2: begin
                cw[C_MEM_RD]  = 1'b1;
                cw[C_MEM_MBR] = 1'b1;
                cw[C_PC_INC]  = 1'b1;
            end
            S_F3: cw[C_MBR_IR] = 1'b1;
            S_E1: begin
                case (op)
                    OP_STORE, OP_LOAD, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_MPY:  cw[C_IR_MAR] = 1'b1;
                    OP_JMP:                 cw[C_IR_PC] = 1'b1;
                    OP_JMPGEZ: begin
                        if (!acc_neg) begin
                            cw[C_IR_PC] = 1'b1;
                        end else begin
                            cw[C_IR_PC] = 1'b0;
                        end
                    end
                    OP_NOT:  begin cw[C_ALU_ACC] = 1'b1; cw[C_NOT]  = 1'b1; end
                    OP_SHR:  begin cw[C_ALU_ACC] = 1'b1; cw[C_SHR]  = 1'b1; end
                    OP_SHL:  begin cw[C_ALU_ACC] = 1'b1; cw[C_SHL]  = 1'b1; end
                    OP_ASHR: begin cw[C_ALU_ACC] = 1'b1; cw[C_ASHR] = 1'b1; end
                    OP_ASHL: begin cw[C_ALU_ACC] = 1'b1; cw[C_ASHL] = 1'b1; end
                    default: cw = {CW_WIDTH{1'b0}};
                endcase
            end
            S_E2: begin
                case (op)
                    OP_STORE: cw[C_ACC_MBR] = 1'b1;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MPY: begin
                        cw[C_MEM_RD]  = 1'b1;
                        cw[C_MEM_MBR] = 1'b1;
                    end
                    default: cw = {CW_WIDTH{1'b0}};
                endcase
            end
            S_E3: begin
                case (op)
                    OP_STORE: cw[C_MEM_WR] = 1'b1;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MPY:
                        cw[C_MBR_BR] = 1'b1;
                    default: cw = {CW_WIDTH{1'b0}};
                endcase
            end
            S_E4: begin
                cw[C_ALU_LATCH] = 1'b1;
                cw[C_ALU_ACC]   = 1'b1;
                case (op)
                    // LOAD goes through the ALU as 0 + BR.
                    OP_LOAD: begin cw[C_CLR_OP1] = 1'b1; cw[C_ADD] = 1'b1; end
                    OP_ADD:  cw[C_ADD] = 1'b1;
                    OP_SUB:  cw[C_SUB] = 1'b1;
                    OP_AND:  cw[C_AND] = 1'b1;
                    OP_OR:   cw[C_OR]  = 1'b1;
                    OP_MPY:  begin cw[C_ALU_MR] = 1'b1; cw[C_MPY] = 1'b1; end
                    default: cw = {CW_WIDTH{1'b0}};
                endcase
            end
            default: cw = {CW_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microprogrammed sequencer: fetch / decode / execute state machine with a
// latched opcode and a registered Moore control word.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int CW_WIDTH = CU_CW_WIDTH,
    parameter int OP_WIDTH = CU_OP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic [7:0]          flag,
    output logic [CW_WIDTH-1:0] control_signal,
    output logic                halted,
    output logic                illegal_op,
    output logic [3:0]          state
);

    logic [3:0]          state_r;
    logic [3:0]          next_state_s;
    logic [OP_WIDTH-1:0] op_r;
    logic [OP_WIDTH-1:0] op_next_s;
    logic [2:0]          steps_s;
    logic                illegal_next_s;
    logic [CW_WIDTH-1:0] cw_next_s;
    logic [CW_WIDTH-1:0] control_signal_r;
    logic                halted_r;
    logic                illegal_op_r;
    logic                unused_flag_s;

    assign unused_flag_s = ^flag[7:1];
    assign steps_s       = exec_steps(op_r);

    // The microrom must see the opcode being latched on the DECODE->E1 edge.
    assign op_next_s = (state_r == S_DECODE) ? opcode : op_r;

    // Next-state selection.
    always_comb begin
        next_state_s   = state_r;
        illegal_next_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_F1;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_F1: next_state_s = S_F2;
            S_F2: next_state_s = S_F3;
            S_F3: next_state_s = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    next_state_s = S_HALT;
                end else if (exec_steps(opcode) == 3'd0) begin
                    next_state_s   = S_F1;
                    illegal_next_s = 1'b1;
                end else begin
                    next_state_s = S_E1;
                end
            end
            S_E1: next_state_s = (steps_s > 3'd1) ? S_E2 : S_F1;
            S_E2: next_state_s = (steps_s > 3'd2) ? S_E3 : S_F1;
            S_E3: next_state_s = (steps_s > 3'd3) ? S_E4 : S_F1;
            S_E4: next_state_s = S_F1;
            S_HALT: next_state_s = S_HALT;
            default: next_state_s = S_IDLE;
        endcase
    end

    cu_microrom #(
        .CW_WIDTH (CW_WIDTH),
        .OP_WIDTH (OP_WIDTH)
    ) u_microrom (
        .state   (next_state_s),
        .op      (op_next_s),
        .acc_neg (flag[0]),
        .cw      (cw_next_s)
    );

    // State, opcode latch and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= S_IDLE;
            op_r             <= {OP_WIDTH{1'b0}};
            control_signal_r <= {CW_WIDTH{1'b0}};
            halted_r         <= 1'b0;
            illegal_op_r     <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            op_r             <= op_next_s;
            control_signal_r <= cw_next_s;
            halted_r         <= (next_state_s == S_HALT);
            illegal_op_r     <= illegal_next_s;
        end
    end

    assign control_signal = control_signal_r;
    assign halted         = halted_r;
    assign illegal_op     = illegal_op_r;
    assign state          = state_r;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues per-cycle expected
// outputs, a monitor pops and compares one entry after every rising edge.
module tb_control_unit;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  opcode;
    logic [7:0]  flag;
    logic [31:0] control_signal;
    logic        halted;
    logic        illegal_op;
    logic [3:0]  state;

    control_unit #(.CW_WIDTH(32), .OP_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .opcode         (opcode),
        .flag           (flag),
        .control_signal (control_signal),
        .halted         (halted),
        .illegal_op     (illegal_op),
        .state          (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cw;
        logic [3:0]  st;
        logic        h;
        logic        il;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string nm, input logic [31:0] cw, input logic [3:0] st,
                         input logic h, input logic il);
        n_vec++;
        if (control_signal !== cw || state !== st || halted !== h || illegal_op !== il) begin
            n_miss++;
            $display("FAIL %s: got cw=%h st=%0d halted=%b illegal=%b, want cw=%h st=%0d halted=%b illegal=%b",
                     nm, control_signal, state, halted, illegal_op, cw, st, h, il);
        end
    endtask

    task automatic push(input logic [31:0] cw, input logic [3:0] st, input logic h,
                        input logic il, input string nm);
        exp_t e;
        e.cw = cw; e.st = st; e.h = h; e.il = il; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic push_fetch(input string nm);
        push(32'h0000_0001, S_F1,     1'b0, 1'b0, {nm, "_f1"});
        push(32'h0000_0026, S_F2,     1'b0, 1'b0, {nm, "_f2"});
        push(32'h0000_0008, S_F3,     1'b0, 1'b0, {nm, "_f3"});
        push(32'h0000_0000, S_DECODE, 1'b0, 1'b0, {nm, "_dec"});
    endtask

    task automatic wait_cycles(input int n);
        @(negedge clk);
        start = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic begin_instr(input logic [7:0] op, input logic [7:0] fl);
        opcode = op;
        flag   = fl;
        start  = 1'b1;
    endtask

    task automatic idle(input int n, input string nm);
        start = 1'b0;
        repeat (n) push(32'h0, S_IDLE, 1'b0, 1'b0, nm);
        wait_cycles(n);
    endtask

    task automatic reset_check(input string nm);
        #2;
        rst = 1'b0;
        #1;
        check(nm, 32'h0, S_IDLE, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
    endtask

    task automatic one_step(input logic [7:0] op, input logic [7:0] fl,
                            input logic [31:0] e1, input string nm);
        begin_instr(op, fl);
        push_fetch(nm);
        push(e1, S_E1, 1'b0, 1'b0, {nm, "_e1"});
        wait_cycles(5);
    endtask

    task automatic alu_instr(input logic [7:0] op, input logic [31:0] e4, input string nm);
        begin_instr(op, 8'h00);
        push_fetch(nm);
        push(32'h0000_0010, S_E1, 1'b0, 1'b0, {nm, "_e1"});
        push(32'h0000_0006, S_E2, 1'b0, 1'b0, {nm, "_e2"});
        push(32'h0000_0040, S_E3, 1'b0, 1'b0, {nm, "_e3"});
        push(e4,            S_E4, 1'b0, 1'b0, {nm, "_e4"});
        wait_cycles(8);
    endtask

    // Monitor: one scoreboard entry per cycle, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.nm, e.cw, e.st, e.h, e.il);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        opcode = 8'h00;
        flag   = 8'h00;
        repeat (2) @(negedge clk);
        check("por_reset", 32'h0, S_IDLE, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(3, "idle_after_por");

        // ADD, with opcode changing during E1 to show it is latched
        begin_instr(8'h03, 8'h00);
        push_fetch("add");
        push(32'h0000_0010, S_E1, 1'b0, 1'b0, "add_e1");
        push(32'h0000_0006, S_E2, 1'b0, 1'b0, "add_e2");
        push(32'h0000_0040, S_E3, 1'b0, 1'b0, "add_e3");
        push(32'h0040_0C00, S_E4, 1'b0, 1'b0, "add_e4");
        wait_cycles(5);
        opcode = 8'h0C;
        wait_cycles(3);

        alu_instr(8'h08, 32'h2000_1C00, "mpy");
        alu_instr(8'h04, 32'h0080_0C00, "sub");
        alu_instr(8'h0B, 32'h0200_0C00, "or");
        one_step(8'h05, 8'h00, 32'h0000_0200, "jmpgez_pos");
        one_step(8'h05, 8'h01, 32'h0000_0000, "jmpgez_neg");
        one_step(8'h06, 8'h01, 32'h0000_0200, "jmp");
        one_step(8'h0C, 8'h00, 32'h0400_0800, "not");
        one_step(8'h0F, 8'h00, 32'h8000_0800, "ashr");
        one_step(8'h10, 8'h00, 32'h4000_0800, "ashl");

        begin_instr(8'h01, 8'h00);
        push_fetch("store");
        push(32'h0000_0010, S_E1, 1'b0, 1'b0, "store_e1");
        push(32'h0000_0080, S_E2, 1'b0, 1'b0, "store_e2");
        push(32'h0000_0100, S_E3, 1'b0, 1'b0, "store_e3");
        wait_cycles(7);

        // LOAD interrupted by reset in the middle of E3
        begin_instr(8'h02, 8'h00);
        push_fetch("load");
        push(32'h0000_0010, S_E1, 1'b0, 1'b0, "load_e1");
        push(32'h0000_0006, S_E2, 1'b0, 1'b0, "load_e2");
        push(32'h0000_0040, S_E3, 1'b0, 1'b0, "load_e3");
        wait_cycles(7);
        reset_check("reset_mid_load");
        idle(4, "idle_after_load_reset");

        alu_instr(8'h02, 32'h0060_0C00, "load");
        reset_check("reset_after_load");
        idle(1, "idle_after_load");

        begin_instr(8'hFF, 8'h00);
        push_fetch("illegal");
        push(32'h0000_0001, S_F1, 1'b0, 1'b1, "illegal_pulse");
        push(32'h0000_0026, S_F2, 1'b0, 1'b0, "illegal_pulse_end");
        wait_cycles(6);
        reset_check("reset_after_illegal");
        idle(2, "idle_after_illegal");

        begin_instr(8'h07, 8'h00);
        push_fetch("halt");
        repeat (20) push(32'h0, S_HALT, 1'b1, 1'b0, "halt_hold");
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            start = ~start;
        end
        reset_check("reset_from_halt");
        idle(3, "idle_after_halt");

        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
